// File: rtl/sprite_anim_pkg.sv
// Shared types and reset defaults for the sprite animation scheduler.
// Optional feature macro used by the scheduler: ANIM_PINGPONG_EN (ping-pong play mode).
package sprite_anim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RUN_REV = 2'd2,
    ST_DONE    = 2'd3
  } anim_state_e;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  localparam int         DEF_FRAMES = 11;
  localparam int         DEF_HOLD   = 0;
  localparam logic [1:0] DEF_MODE   = MODE_LOOP;

  function automatic logic is_oneshot(input logic [1:0] mode);
    return mode == MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/sprite_anim_prescaler.sv
// Free-running animation tick prescaler; tick is a registered one-cycle pulse
// in the cycle the count sits at TICK_DIV-1. clr restarts the count at 0.
module sprite_anim_prescaler #(
  parameter int TICK_DIV = 6240000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (clr || cnt == LAST) cnt_nxt = '0;
  end

  // tick is registered from the next count so it lines up with count==LAST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/sprite_anim_scheduler.sv
// Multi-channel sprite frame sequencer driven by one shared tick prescaler.
// Define ANIM_PINGPONG_EN to enable ping-pong mode (cfg_mode 10); otherwise 10 plays as loop.
module sprite_anim_scheduler
  import sprite_anim_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         FRAME_W     = 5,
  parameter int         HOLD_W      = 4,
  parameter int         TICK_DIV    = 6240000,
  parameter logic [7:0] RESTART_KEY = 8'h2B
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 keycode,
  input  logic                       press,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_ch,
  input  logic [FRAME_W-1:0]         cfg_frames,
  input  logic [HOLD_W-1:0]          cfg_hold,
  input  logic [1:0]                 cfg_mode,
  input  logic [NUM_CH-1:0]          start,
  input  logic [NUM_CH-1:0]          stop,
  output logic [NUM_CH*FRAME_W-1:0]  frame_num,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH-1:0]          done,
  output logic                       tick
);

  logic restart;
  assign restart = press && (keycode == RESTART_KEY);

  sprite_anim_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .tick  (tick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    anim_state_e        state_q;
    logic [FRAME_W-1:0] frame_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [FRAME_W-1:0] cfg_frames_q;
    logic [HOLD_W-1:0]  cfg_hold_q;
    logic [1:0]         cfg_mode_q;
    logic               done_q;
    logic [FRAME_W-1:0] last_frame;
    logic               running;

    // a frame count of 0 is treated as a single frame
    assign last_frame = (cfg_frames_q == '0) ? '0 : cfg_frames_q - FRAME_W'(1);
    assign running    = (state_q == ST_RUN) || (state_q == ST_RUN_REV);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cfg_frames_q <= FRAME_W'(DEF_FRAMES);
        cfg_hold_q   <= HOLD_W'(DEF_HOLD);
        cfg_mode_q   <= DEF_MODE;
      end else if (cfg_we && cfg_ch == 3'(i)) begin
        cfg_frames_q <= cfg_frames;
        cfg_hold_q   <= cfg_hold;
        cfg_mode_q   <= cfg_mode;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= ST_IDLE;
        frame_q <= '0;
        hold_q  <= '0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (restart) begin
          if (state_q != ST_IDLE) begin
            state_q <= ST_RUN;
            frame_q <= '0;
            hold_q  <= '0;
          end
        end else if (stop[i]) begin
          state_q <= ST_IDLE;
        end else if (start[i]) begin
          state_q <= ST_RUN;
          frame_q <= '0;
          hold_q  <= '0;
        end else if (tick && running) begin
          if (hold_q < cfg_hold_q) begin
            hold_q <= hold_q + HOLD_W'(1);
          end else begin
            hold_q <= '0;
            case (state_q)
              ST_RUN: begin
                if (frame_q < last_frame) begin
                  frame_q <= frame_q + FRAME_W'(1);
                end else if (is_oneshot(cfg_mode_q)) begin
                  state_q <= ST_DONE;
                  frame_q <= last_frame;
                  done_q  <= 1'b1;
                end
`ifdef ANIM_PINGPONG_EN
                else if (cfg_mode_q == MODE_PINGPONG) begin
                  state_q <= ST_RUN_REV;
                  frame_q <= (last_frame == '0) ? '0 : frame_q - FRAME_W'(1);
                end
`endif
                else begin
                  frame_q <= '0;
                end
              end
`ifdef ANIM_PINGPONG_EN
              ST_RUN_REV: begin
                if (frame_q != '0) begin
                  frame_q <= frame_q - FRAME_W'(1);
                end else begin
                  state_q <= ST_RUN;
                  frame_q <= (last_frame == '0) ? '0 : FRAME_W'(1);
                end
              end
`endif
              default: ;
            endcase
          end
        end
      end
    end

    assign frame_num[i*FRAME_W +: FRAME_W] = frame_q;
    assign busy[i]                         = running;
    assign done[i]                         = done_q;
  end

endmodule

// File: tb/tb_sprite_anim_scheduler.sv
// Directed bench for sprite_anim_scheduler with a 4-cycle tick; expectations
// follow ANIM_PINGPONG_EN when the bench is built with it.
module tb_sprite_anim_scheduler;

  logic        clk;
  logic        reset;
  logic [7:0]  keycode;
  logic        press;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [4:0]  cfg_frames;
  logic [3:0]  cfg_hold;
  logic [1:0]  cfg_mode;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic [19:0] frame_num;
  logic [3:0]  busy;
  logic [3:0]  done;
  logic        tick;

  int compared   = 0;
  int mismatched = 0;

  sprite_anim_scheduler #(
    .NUM_CH      (4),
    .FRAME_W     (5),
    .HOLD_W      (4),
    .TICK_DIV    (4),
    .RESTART_KEY (8'h2B)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keycode    (keycode),
    .press      (press),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_frames (cfg_frames),
    .cfg_hold   (cfg_hold),
    .cfg_mode   (cfg_mode),
    .start      (start),
    .stop       (stop),
    .frame_num  (frame_num),
    .busy       (busy),
    .done       (done),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] fr(input int ch);
    return frame_num[ch*5 +: 5];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Return at the negedge just after the edge that consumed the next tick.
  task automatic next_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", {31'd0, tick}, 32'd1);
    @(negedge clk);
  endtask

  task automatic cfg(input logic [2:0] ch, input logic [4:0] f, input logic [3:0] h, input logic [1:0] m);
    cfg_we = 1'b1; cfg_ch = ch; cfg_frames = f; cfg_hold = h; cfg_mode = m;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] m);
    start = m;
    step();
    start = '0;
  endtask

  int exp_pp [7];
  int held;

  initial begin
    reset = 1'b0; keycode = '0; press = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_frames = '0; cfg_hold = '0; cfg_mode = '0; start = '0; stop = '0;
`ifdef ANIM_PINGPONG_EN
    exp_pp = '{1, 2, 3, 2, 1, 0, 1};
`else
    exp_pp = '{1, 2, 3, 0, 1, 2, 3};
`endif

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_frame", {12'd0, frame_num}, 32'd0);
    chk("rst_busy", {28'd0, busy}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // ch0 loop, 3 frames, hold 0
    cfg(3'd0, 5'd3, 4'd0, 2'b00);
    pulse_start(4'b0001);
    chk("ch0_start_frame", fr(0), 32'd0);
    chk("ch0_start_busy", busy[0], 32'd1);
    next_tick(); chk("ch0_loop_t1", fr(0), 32'd1);
    next_tick(); chk("ch0_loop_t2", fr(0), 32'd2);
    next_tick(); chk("ch0_loop_t3", fr(0), 32'd0);
    next_tick(); chk("ch0_loop_t4", fr(0), 32'd1);
    chk("ch0_loop_busy", busy[0], 32'd1);

    // prescaler period of 4 cycles
    chk("tick_period_0", tick, 32'd0);
    step(); chk("tick_period_1", tick, 32'd0);
    step(); chk("tick_period_2", tick, 32'd0);
    step(); chk("tick_period_3", tick, 32'd1);

    // ch1 one-shot, 2 frames, hold 1
    cfg(3'd1, 5'd2, 4'd1, 2'b01);
    pulse_start(4'b0010);
    chk("ch1_start_frame", fr(1), 32'd0);
    next_tick(); chk("ch1_t1", fr(1), 32'd0);
    next_tick(); chk("ch1_t2", fr(1), 32'd1);
    next_tick(); chk("ch1_t3", fr(1), 32'd1);
    chk("ch1_t3_busy", busy[1], 32'd1);
    chk("ch1_t3_done", done[1], 32'd0);
    next_tick();
    chk("ch1_done_pulse", done[1], 32'd1);
    chk("ch1_done_busy", busy[1], 32'd0);
    chk("ch1_done_frame", fr(1), 32'd1);
    step();
    chk("ch1_done_clear", done[1], 32'd0);
    chk("ch1_done_hold", fr(1), 32'd1);

    // ch2 ping-pong (or loop without the feature), 4 frames
    cfg(3'd2, 5'd4, 4'd0, 2'b10);
    pulse_start(4'b0100);
    chk("ch2_start_frame", fr(2), 32'd0);
    for (int k = 0; k < 7; k++) begin
      next_tick();
      chk($sformatf("ch2_seq_%0d", k), fr(2), exp_pp[k]);
    end
    chk("ch2_busy", busy[2], 32'd1);
    held = exp_pp[6];
    stop = 4'b0100;
    step();
    stop = '0;
    chk("ch2_stop_busy", busy[2], 32'd0);
    chk("ch2_stop_frame", fr(2), held);

    // restart key: ch0 running at frame 2, ch1 in DONE, ch2/ch3 idle
    pulse_start(4'b0001);
    next_tick(); chk("ch0_pre_t1", fr(0), 32'd1);
    next_tick(); chk("ch0_pre_t2", fr(0), 32'd2);
    keycode = 8'h2C; press = 1'b1;
    step();
    chk("wrong_key_frame", fr(0), 32'd2);
    keycode = 8'h2B;
    step();
    keycode = '0; press = 1'b0;
    chk("rk_ch0_frame", fr(0), 32'd0);
    chk("rk_ch0_busy", busy[0], 32'd1);
    chk("rk_ch1_frame", fr(1), 32'd0);
    chk("rk_ch1_busy", busy[1], 32'd1);
    chk("rk_ch2_idle", busy[2], 32'd0);
    chk("rk_ch3_idle", busy[3], 32'd0);
    chk("rk_tick_0", tick, 32'd0);
    step(); chk("rk_tick_1", tick, 32'd0);
    step(); chk("rk_tick_2", tick, 32'd0);
    step(); chk("rk_tick_3", tick, 32'd1);
    step();

    // start and stop together: stop wins
    start = 4'b0001; stop = 4'b0001;
    step();
    start = '0; stop = '0;
    chk("startstop_busy", busy[0], 32'd0);

    // restart key and stop together: restart wins
    stop = 4'b0010; keycode = 8'h2B; press = 1'b1;
    step();
    stop = '0; keycode = '0; press = 1'b0;
    chk("rkstop_ch1_busy", busy[1], 32'd1);
    chk("rkstop_ch1_frame", fr(1), 32'd0);
    chk("rkstop_ch0_idle", busy[0], 32'd0);

    // frame count 0 behaves as a single frame
    cfg(3'd3, 5'd0, 4'd0, 2'b00);
    pulse_start(4'b1000);
    next_tick(); chk("ch3_f0_t1", fr(3), 32'd0);
    next_tick(); chk("ch3_f0_t2", fr(3), 32'd0);
    chk("ch3_f0_busy", busy[3], 32'd1);

    // asynchronous reset mid-animation
    reset = 1'b0;
    #1;
    chk("arst_frame", {12'd0, frame_num}, 32'd0);
    chk("arst_busy", {28'd0, busy}, 32'd0);
    chk("arst_done", {28'd0, done}, 32'd0);
    chk("arst_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // default config: 11 frames, hold 0, loop
    pulse_start(4'b0001);
    chk("def_start", fr(0), 32'd0);
    for (int k = 1; k <= 11; k++) begin
      next_tick();
      chk($sformatf("def_seq_%0d", k), fr(0), k % 11);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sprite_anim_scheduler.md
# sprite_anim_scheduler

Multi-channel sprite animation scheduler that sequences the frame index for up to NUM_CH independent sprite animations (candy, character, barrel, …) from one shared frame-rate prescaler. Each channel has run-time frame count, hold length and play mode, plus start/stop controls and a global keyboard restart. The scheduler drives the frame-select inputs of the sprite ROM address logic and replaces the per-sprite hard-coded frame state machines.

## Interface
- NUM_CH, 4, number of animation channels (1..8)
- FRAME_W, 5, frame index width
- HOLD_W, 4, hold-count width
- TICK_DIV, 6240000, clk cycles per animation tick (≥2)
- RESTART_KEY, 8'h2B, keycode that restarts all active channels

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- keycode  in  8  keyboard scan code
- press  in  1  key-press qualifier for keycode
- cfg_we  in  1  config write strobe
- cfg_ch  in  3  channel selected for config write
- cfg_frames  in  FRAME_W  frame count; 0 treated as 1
- cfg_hold  in  HOLD_W  ticks per frame minus 1
- cfg_mode  in  2  00 loop, 01 one-shot, 10 ping-pong, 11 loop
- start  in  NUM_CH  per-channel start pulse mask
- stop  in  NUM_CH  per-channel stop pulse mask
- frame_num  out  NUM_CH*FRAME_W  packed frame index, channel 0 in LSBs
- busy  out  NUM_CH  channel in RUN or RUN_REV
- done  out  NUM_CH  one-cycle pulse when a one-shot finishes
- tick  out  1  one-cycle prescaler pulse

## Operation
- Prescaler: counts 0..TICK_DIV-1, wraps; tick=1 in the cycle count==TICK_DIV-1. Cleared only by reset and restart key.
- Per-channel states: IDLE, RUN, RUN_REV, DONE.
- Reset: all channels IDLE, frame 0, hold counter 0; config = frames 11, hold 0, mode loop; outputs 0.
- Config write (cfg_we): updates channel cfg_ch immediately; cfg_ch ≥ NUM_CH ignored; frame/state untouched.
- start[i]: → RUN, frame 0, hold counter 0.
- stop[i]: → IDLE, frame_num held.
- Advance on tick in RUN/RUN_REV: if hold_cnt < cfg_hold, hold_cnt+1; else hold_cnt=0 and step frame.
- RUN step: frame < last (frames-1) → +1; frame ≥ last → loop: 0; one-shot: DONE, frame=last, done pulse; ping-pong: RUN_REV, frame-1 (stays 0 if frames=1).
- RUN_REV step: frame > 0 → -1; frame 0 → RUN, frame 1 (0 if frames=1).
- Frame count reduced while running: frame ≥ new last resolves at next step per rules above.
- Restart key (keycode==RESTART_KEY && press): prescaler 0; every channel not IDLE → RUN, frame 0, hold 0; IDLE stays IDLE.
- Priority: reset > restart key > stop > start > tick advance. Config write is independent and may coincide.
- DONE: frame held, busy 0; exits only via start, stop, restart key.

## Timing
- All outputs registered; frame_num/busy/done change the cycle after the causing tick/start/stop/key.
- start → busy=1 and frame 0 next cycle; first frame lasts until the next free-running tick (not aligned).
- done high exactly one cycle per one-shot completion.
- Reset asynchronous assert; synchronous deassertion handled upstream.

## Configuration
- ANIM_PINGPONG_EN defined: cfg_mode 10 selects ping-pong; RUN_REV implemented.
- Undefined: RUN_REV absent; cfg_mode 10 behaves as loop; port width unchanged.

## Structure
- sprite_anim_pkg: state enum, mode encoding constants, reset defaults (11 frames, hold 0, loop).
- Sub-module sprite_anim_prescaler: tick counter with synchronous clear; channel logic in a generate loop.

## Test plan
- TICK_DIV=4, ch0 frames 3, hold 0, loop, start → frame_num 0,1,2,0 on successive ticks; busy=1.
- ch1 frames 2, hold 1, one-shot, start → frame 1 after 2 ticks, DONE after 4 ticks, done one-cycle pulse, frame stays 1, busy 0.
- ANIM_PINGPONG_EN, ch2 frames 4 ping-pong → 0,1,2,3,2,1,0,1; without macro → 0,1,2,3,0.
- ch0 at frame 2 running, ch3 IDLE, keycode 8'h2B with press → ch0 frame 0 next cycle, prescaler 0, ch3 stays IDLE.
- Same-cycle start[0] and stop[0] → IDLE; same-cycle restart key and stop → restart wins.
- Assert reset mid-animation → all frame_num 0, busy 0, done 0, tick 0 immediately, config back to defaults.
